tx_byte_scheduler: RTL and testbench
====================================

// Module: tx_byte_scheduler
// PURPOSE
//  Outbound byte queue and UART-TX sequencer between Handout (move/handshake byte
//  producer) and the M1_UART transmitter. Buffers bytes written by Handout, then
//  sends them one at a time with the TxD_start/TxD_busy handshake. Enforces a
//  programmable idle gap between bytes and retries a start the UART failed to accept.
//  Replaces the fifo + fifo2transmit pair; lossless up to DEPTH bytes.
// PARAMETERS
//  ADDR_W      3    log2 of queue depth (DEPTH = 2**ADDR_W = 8 bytes)
//  GAP_CYCLES  16   idle clk cycles after TxD_busy falls before next start (0 = no gap)
//  BUSY_TO     64   clk cycles to wait for TxD_busy to rise after TxD_start before retry
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  rst          in   1         asynchronous, active-high reset
//  wr_en        in   1         push buf_in this cycle
//  buf_in       in   8         byte to queue
//  buf_full     out  1         queue holds DEPTH bytes
//  buf_empty    out  1         queue holds 0 bytes
//  fifo_counter out  ADDR_W+1  current occupancy, 0..DEPTH
//  overflow     out  1         sticky: a push was dropped
//  TxD_busy     in   1         UART transmitter busy
//  TxD_start    out  1         one-cycle start strobe to UART
//  TxD_data     out  8         byte presented to UART, held stable START..WAIT_LO
// BEHAVIOUR
//  Reset (async, any state): wr/rd pointers=0, fifo_counter=0, buf_empty=1,
//   buf_full=0, overflow=0, TxD_start=0, TxD_data=8'h00, FSM=IDLE, counters=0.
//  Queue: circular RAM, ADDR_W-bit pointers wrap DEPTH-1 -> 0. Flags and counter are
//   registered, updated the cycle after the push/pop.
//  Push accepted iff wr_en && (!buf_full || pop this cycle); when full and a pop
//   happens in the same cycle the push is accepted and the counter is unchanged.
//  Push while full with no pop: byte dropped, pointers unchanged, overflow<=1
//   (cleared only by rst).
//  Pop happens only in the FSM LOAD state; a push and pop in the same cycle with
//   counter=0 is impossible (LOAD requires !buf_empty).
//  FSM:
//   IDLE   : if !buf_empty && !TxD_busy -> LOAD; else stay.
//   LOAD   : TxD_data<=head byte, rd_ptr++, counter-- -> START.
//   START  : TxD_start=1 for exactly this cycle, to_cnt<=0 -> WAIT_HI.
//   WAIT_HI: if TxD_busy -> WAIT_LO; else to_cnt++; at to_cnt==BUSY_TO-1 -> START
//            (same byte re-sent, no pop; infinite retries).
//   WAIT_LO: if !TxD_busy -> GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES==0).
//   GAP    : gap_cnt counts 0..GAP_CYCLES-1 -> IDLE.
//  TxD_start is high only in START; it never asserts while TxD_busy=1 at entry to LOAD.
//  Latency: push at cycle n into an empty queue with FSM IDLE and TxD_busy=0:
//   buf_empty falls at n+1; LOAD at n+1; TxD_start high at n+2.
//  Back-to-back throughput: one byte per UART frame + GAP_CYCLES + 3 cycles.
//  TxD_data changes only in LOAD; it is held through retries.
// TESTING
//  1 Single byte: push 8'hA5 into empty queue, UART model busy 10 cycles after start
//    -> TxD_start one pulse 2 cycles after push, TxD_data=A5, buf_empty=1 afterwards.
//  2 Fill/overflow: 9 pushes in 9 cycles with TxD_busy held 1 -> fifo_counter=8,
//    buf_full=1, overflow=1; release busy -> bytes 1..8 sent in order, 9th never sent.
//  3 Push+pop when full: count=8, wr_en during LOAD -> byte accepted, counter stays 8,
//    overflow stays 0, byte transmitted last.
//  4 Missed start: UART ignores first TxD_start (busy stays 0) -> second TxD_start
//    exactly BUSY_TO+1 cycles later with same TxD_data; no byte lost or duplicated.
//  5 Gap: two queued bytes, busy low at cycle t -> next TxD_start at t+GAP_CYCLES+3
//    (GAP_CYCLES=16 -> t+19).
//  6 Async reset in WAIT_LO with 5 bytes queued -> outputs at reset values at once,
//    no TxD_start; after release, 2 new pushes -> only those 2 bytes sent.

Source files
------------

// File: rtl/tx_byte_scheduler.sv
// tx_byte_scheduler: circular byte queue that feeds a UART transmitter through a
// start/busy handshake. It retries a start the UART did not accept and enforces an idle gap between bytes.
module tx_byte_scheduler #(
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_TO    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        buf_in,
  output logic              buf_full,
  output logic              buf_empty,
  output logic [ADDR_W:0]   fifo_counter,
  output logic              overflow,
  input  logic              TxD_busy,
  output logic              TxD_start,
  output logic [7:0]        TxD_data
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W    = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_ZERO  = TO_W'(0);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(BUSY_TO - 1);
  localparam logic [GAP_W-1:0]  GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_next_s;
  logic              full_r;
  logic              empty_r;
  logic              overflow_r;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  state_t            state_r;
  state_t            state_next_s;
  logic [TO_W-1:0]   to_cnt_r;
  logic [TO_W-1:0]   to_cnt_next_s;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_next_s;
  logic              tx_start_r;
  logic [7:0]        tx_data_r;

  // A full queue still takes a push when the same cycle pops, since a slot frees up.
  assign pop_s  = (state_r == ST_LOAD);
  assign push_s = wr_en && (!full_r || pop_s);
  assign drop_s = wr_en && full_r && !pop_s;

  // Occupancy for the next cycle.
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Queue pointers, occupancy, registered flags and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (drop_s) overflow_r <= 1'b1;
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_FULL);
      empty_r <= (count_next_s == CNT_ZERO);
    end
  end

  // Byte storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= buf_in;
  end

  // Next-state logic for the transmit sequencer and its two counters.
  always_comb begin
    state_next_s   = state_r;
    to_cnt_next_s  = to_cnt_r;
    gap_cnt_next_s = gap_cnt_r;
    case (state_r)
      // Next occupancy is used so that a push into an empty queue loads on the following cycle.
      ST_IDLE: begin
        if ((count_next_s != CNT_ZERO) && !TxD_busy) state_next_s = ST_LOAD;
        else state_next_s = ST_IDLE;
      end
      ST_LOAD: state_next_s = ST_START;
      ST_START: begin
        to_cnt_next_s = TO_ZERO;
        state_next_s  = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (TxD_busy) state_next_s = ST_WAIT_LO;
        else if (to_cnt_r == TO_LAST) state_next_s = ST_START;
        else to_cnt_next_s = to_cnt_r + TO_ONE;
      end
      ST_WAIT_LO: begin
        if (!TxD_busy) begin
          gap_cnt_next_s = GAP_ZERO;
          if (HAS_GAP) state_next_s = ST_GAP;
          else state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_LO;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          gap_cnt_next_s = GAP_ZERO;
          state_next_s   = ST_IDLE;
        end else begin
          gap_cnt_next_s = gap_cnt_r + GAP_ONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Sequencer state plus registered UART outputs; the start strobe is aligned with START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      to_cnt_r   <= TO_ZERO;
      gap_cnt_r  <= GAP_ZERO;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      state_r    <= state_next_s;
      to_cnt_r   <= to_cnt_next_s;
      gap_cnt_r  <= gap_cnt_next_s;
      tx_start_r <= (state_next_s == ST_START);
      if (pop_s) tx_data_r <= mem_r[rd_ptr_r];
    end
  end

  assign buf_full     = full_r;
  assign buf_empty    = empty_r;
  assign fifo_counter = count_r;
  assign overflow     = overflow_r;
  assign TxD_start    = tx_start_r;
  assign TxD_data     = tx_data_r;

endmodule

// File: tb/tb_tx_byte_scheduler.sv
// Directed bench for tx_byte_scheduler with a small UART responder model that
// logs every start strobe (byte and cycle) for ordering and timing checks.
module tb_tx_byte_scheduler;

  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] buf_in;
  logic       buf_full;
  logic       buf_empty;
  logic [3:0] fifo_counter;
  logic       overflow;
  logic       TxD_busy;
  logic       TxD_start;
  logic [7:0] TxD_data;

  logic       force_busy;
  int         ignore_idx;
  int         busy_cnt = 0;
  int         start_count = 0;
  int         cyc = 0;
  logic [7:0] log_byte[$];
  int         log_cyc[$];

  int n_vec = 0;
  int n_err = 0;

  tx_byte_scheduler #(.ADDR_W(3), .GAP_CYCLES(16), .BUSY_TO(64)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .buf_in(buf_in),
    .buf_full(buf_full), .buf_empty(buf_empty), .fifo_counter(fifo_counter),
    .overflow(overflow), .TxD_busy(TxD_busy), .TxD_start(TxD_start),
    .TxD_data(TxD_data)
  );

  always #5 clk = ~clk;

  assign TxD_busy = force_busy | (busy_cnt != 0);

  // UART responder: busy for FRAME cycles after an accepted start; one start may be ignored.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (TxD_start) begin
      log_byte.push_back(TxD_data);
      log_cyc.push_back(cyc);
      if (start_count != ignore_idx) busy_cnt <= FRAME;
      start_count <= start_count + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int idx, input logic [7:0] exp_b);
    logic [31:0] obs;
    obs = (idx < log_byte.size()) ? 32'(log_byte[idx]) : 32'hFFFF_FFFF;
    check(tag, obs, 32'(exp_b));
  endtask

  function automatic int cyc_at(input int idx);
    return (idx < log_cyc.size()) ? log_cyc[idx] : -100000;
  endfunction

  task automatic push(input logic [7:0] b);
    wr_en  = 1'b1;
    buf_in = b;
    step(1);
    wr_en  = 1'b0;
  endtask

  initial begin
    int base;
    int c_push;
    rst = 1'b1; wr_en = 1'b0; buf_in = 8'h00; force_busy = 1'b0; ignore_idx = -1;
    step(3);
    check("rst_empty", 32'(buf_empty), 32'd1);
    check("rst_full", 32'(buf_full), 32'd0);
    check("rst_count", 32'(fifo_counter), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_start", 32'(TxD_start), 32'd0);
    check("rst_data", 32'(TxD_data), 32'h00);
    rst = 1'b0;
    step(2);

    // Single byte: start strobe two cycles after the push
    base = log_byte.size();
    c_push = cyc;
    wr_en = 1'b1; buf_in = 8'hA5;
    step(1);
    wr_en = 1'b0;
    check("t1_count_n1", 32'(fifo_counter), 32'd1);
    check("t1_empty_n1", 32'(buf_empty), 32'd0);
    check("t1_start_n1", 32'(TxD_start), 32'd0);
    step(1);
    check("t1_start_n2", 32'(TxD_start), 32'd1);
    check("t1_data_n2", 32'(TxD_data), 32'hA5);
    check("t1_empty_n2", 32'(buf_empty), 32'd1);
    step(1);
    check("t1_start_n3", 32'(TxD_start), 32'd0);
    step(40);
    check("t1_nsent", 32'(log_byte.size() - base), 32'd1);
    check_log("t1_byte", base, 8'hA5);
    check("t1_latency", 32'(cyc_at(base) - c_push), 32'd2);

    // Gap: starts spaced by 1 + FRAME + GAP_CYCLES + 3 cycles
    base = log_byte.size();
    push(8'hC1);
    push(8'hC2);
    step(70);
    check("t5_nsent", 32'(log_byte.size() - base), 32'd2);
    check_log("t5_b0", base, 8'hC1);
    check_log("t5_b1", base + 1, 8'hC2);
    check("t5_spacing", 32'(cyc_at(base + 1) - cyc_at(base)), 32'd30);
    check("t5_count", 32'(fifo_counter), 32'd0);

    // Fill and overflow while the UART is held busy
    base = log_byte.size();
    force_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    check("t2_count8", 32'(fifo_counter), 32'd8);
    check("t2_full8", 32'(buf_full), 32'd1);
    check("t2_ovf8", 32'(overflow), 32'd0);
    push(8'h19);
    check("t2_count9", 32'(fifo_counter), 32'd8);
    check("t2_ovf9", 32'(overflow), 32'd1);
    check("t2_nostart", 32'(log_byte.size() - base), 32'd0);
    force_busy = 1'b0;
    step(280);
    check("t2_nsent", 32'(log_byte.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) check_log("t2_order", base + i, 8'h11 + 8'(i));
    check("t2_empty", 32'(buf_empty), 32'd1);
    check("t2_ovf_sticky", 32'(overflow), 32'd1);

    // Push during LOAD with a full queue
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    check("t3_ovf_rst", 32'(overflow), 32'd0);
    base = log_byte.size();
    force_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h21 + 8'(i));
    force_busy = 1'b0;
    step(1);
    check("t3_count_load", 32'(fifo_counter), 32'd8);
    wr_en = 1'b1; buf_in = 8'h29;
    step(1);
    wr_en = 1'b0;
    check("t3_count_after", 32'(fifo_counter), 32'd8);
    check("t3_full_after", 32'(buf_full), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd0);
    check("t3_start", 32'(TxD_start), 32'd1);
    check("t3_data", 32'(TxD_data), 32'h21);
    step(300);
    check("t3_nsent", 32'(log_byte.size() - base), 32'd9);
    for (int i = 0; i < 9; i++) check_log("t3_order", base + i, 8'h21 + 8'(i));
    check("t3_ovf_end", 32'(overflow), 32'd0);

    // Missed start: retry BUSY_TO+1 cycles later with the same byte
    base = log_byte.size();
    ignore_idx = start_count;
    push(8'h3C);
    push(8'h3D);
    step(140);
    check("t4_nsent", 32'(log_byte.size() - base), 32'd3);
    check_log("t4_b0", base, 8'h3C);
    check_log("t4_retry", base + 1, 8'h3C);
    check_log("t4_b1", base + 2, 8'h3D);
    check("t4_retry_gap", 32'(cyc_at(base + 1) - cyc_at(base)), 32'd65);
    ignore_idx = -1;

    // Async reset while waiting for busy to fall with 5 bytes still queued
    base = log_byte.size();
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h41 + 8'(i));
    force_busy = 1'b0;
    step(6);
    check("t6_count_pre", 32'(fifo_counter), 32'd5);
    check("t6_busy_pre", 32'(TxD_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_count_rst", 32'(fifo_counter), 32'd0);
    check("t6_empty_rst", 32'(buf_empty), 32'd1);
    check("t6_full_rst", 32'(buf_full), 32'd0);
    check("t6_start_rst", 32'(TxD_start), 32'd0);
    check("t6_data_rst", 32'(TxD_data), 32'h00);
    step(2);
    rst = 1'b0;
    push(8'h51);
    push(8'h52);
    step(100);
    check("t6_nsent", 32'(log_byte.size() - base), 32'd3);
    check_log("t6_first", base, 8'h41);
    check_log("t6_new0", base + 1, 8'h51);
    check_log("t6_new1", base + 2, 8'h52);
    check("t6_empty_end", 32'(buf_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
